data_mem_controller: RTL and testbench

Multi-cycle data memory for the MEM stage of the five-stage pipeline. It accepts one load or store per MEM-stage instruction and performs it after a fixed LATENCY-cycle access time. It holds memready_m low until the access completes, which is the signal the hazard detector uses to stall F/D/E/M and flush W. On completion it presents load data to the MEM/WB register.

---
 rtl/data_mem_controller.sv | 102 ++++++++++
 tb/tb_data_mem_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_controller.sv
// Multi-cycle MEM-stage data memory: one load/store per request, completed after a
// fixed LATENCY-cycle access, signalled by a one-cycle memready_m pulse.
module data_mem_controller #(
   parameter int LATENCY = 20,
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memread_m,
   input  logic              memwrite_m,
   input  logic [31:0]       aluout_m,
   input  logic [DATA_W-1:0] writedata_m,
   output logic [DATA_W-1:0] readdata_m,
   output logic              memready_m,
   output logic              misalign_err
);

   localparam int              CNT_W    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 2);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              accept;
   logic              finish;

   logic [ADDR_W-1:0] idx_q;
   logic [DATA_W-1:0] wdata_q;
   logic              write_q;

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Address bits above the word index wrap around by design.
   logic unused_addr_bits;
   assign unused_addr_bits = ^aluout_m[31:ADDR_W+2];

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (memread_m || memwrite_m) begin
               accept    = 1'b1;
               cnt_nxt   = CNT_INIT;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (cnt == '0) begin
               finish    = 1'b1;
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         memready_m   <= 1'b0;
         readdata_m   <= '0;
         misalign_err <= 1'b0;
         idx_q        <= '0;
         wdata_q      <= '0;
         write_q      <= 1'b0;
      end else begin
         memready_m <= finish;
         if (accept) begin
            idx_q   <= aluout_m[ADDR_W+1:2];
            wdata_q <= writedata_m;
            write_q <= memwrite_m;  // a store wins when both strobes are high
            if (aluout_m[1:0] != 2'b00) misalign_err <= 1'b1;
         end
         if (finish && !write_q) readdata_m <= mem[idx_q];
      end
   end

   // NOTE: the storage array has no reset; reset only blocks a pending write.
   always_ff @(posedge clk) begin
      if (!reset && finish && write_q) mem[idx_q] <= wdata_q;
   end

endmodule

// File: tb/tb_data_mem_controller.sv
// Directed self-checking bench for data_mem_controller: a LATENCY=20 instance for the
// vector table and reset corners, a LATENCY=5 instance for back-to-back loads.
module tb_data_mem_controller;

   localparam int L20 = 20;
   localparam int L5  = 5;

   logic        clk = 1'b0;
   logic        reset;
   logic        memread_m, memwrite_m;
   logic [31:0] aluout_m, writedata_m;
   logic [31:0] rd20, rd5;
   logic        rdy20, rdy5, mis20, mis5;

   logic        use5 = 1'b0;
   logic        rdy_s, mis_s;
   logic [31:0] rd_s;
   assign rdy_s = use5 ? rdy5 : rdy20;
   assign mis_s = use5 ? mis5 : mis20;
   assign rd_s  = use5 ? rd5  : rd20;

   int cyc = 0;
   int n_vec = 0;
   int n_fail = 0;

   data_mem_controller #(.LATENCY(L20), .ADDR_W(10), .DATA_W(32)) u_l20 (
      .clk(clk), .reset(reset), .memread_m(memread_m), .memwrite_m(memwrite_m),
      .aluout_m(aluout_m), .writedata_m(writedata_m),
      .readdata_m(rd20), .memready_m(rdy20), .misalign_err(mis20));

   data_mem_controller #(.LATENCY(L5), .ADDR_W(10), .DATA_W(32)) u_l5 (
      .clk(clk), .reset(reset), .memread_m(memread_m), .memwrite_m(memwrite_m),
      .aluout_m(aluout_m), .writedata_m(writedata_m),
      .readdata_m(rd5), .memready_m(rdy5), .misalign_err(mis5));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // memready_m must never be high in two consecutive cycles.
   logic prev20 = 1'b0, prev5 = 1'b0;
   always @(negedge clk) begin
      if (rdy20) check("no_consec_l20", {31'b0, prev20}, 32'h0);
      if (rdy5)  check("no_consec_l5",  {31'b0, prev5},  32'h0);
      prev20 = rdy20;
      prev5  = rdy5;
   end

   // Called just after the request is driven; lat = cycles from request cycle to pulse.
   // Address/data are scrambled after the first cycle to prove the captured copies are used.
   task automatic wait_pulse(input logic [31:0] addr, input logic [31:0] wdata,
                             output int lat, output int pcyc);
      lat  = -1;
      pcyc = -1;
      for (int i = 0; i <= L20 + 4; i++) begin
         if (i > 0) begin
            @(posedge clk); #1;
            aluout_m    = ~addr;
            writedata_m = ~wdata;
         end
         @(negedge clk);
         if (rdy_s) begin
            lat  = i;
            pcyc = cyc;
            break;
         end
      end
   endtask

   task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, output int lat, output int pcyc);
      @(posedge clk); #1;
      memread_m   = rd;
      memwrite_m  = wr;
      aluout_m    = addr;
      writedata_m = wdata;
      wait_pulse(addr, wdata, lat, pcyc);
   endtask

   task automatic go_idle();
      @(posedge clk); #1;
      memread_m  = 1'b0;
      memwrite_m = 1'b0;
   endtask

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic        exp_mis;
   } vec_t;

   vec_t vecs[14];

   initial begin
      int lat, pcyc, p1, pulses;

      //            rd    wr    addr          wdata         chk   exp_rd        mis
      vecs[0]  = '{1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 32'h0,        1'b0};
      vecs[1]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 32'h0000_0080, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,         1'b1, 32'h0000_0000, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h1111_1111, 1'b1, 32'h0000_0000, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 32'h0000_0004, 32'h2222_2222, 1'b1, 32'h0000_0000, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'h1111_1111, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         1'b1, 32'h2222_2222, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 1'b1, 32'h2222_2222, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hA5A5_A5A5, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h0BAD_F00D, 1'b1, 32'hA5A5_A5A5, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 32'h0000_3FFC, 32'h0,         1'b1, 32'h0BAD_F00D, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 32'h0000_0041, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b1};
      vecs[13] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         1'b1, 32'h2222_2222, 1'b1};

      // Reset held two cycles with a load pending: nothing moves until release.
      reset       = 1'b1;
      memread_m   = 1'b1;
      memwrite_m  = 1'b0;
      aluout_m    = 32'h40;
      writedata_m = 32'h0;
      for (int r = 0; r < 2; r++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check($sformatf("rst%0d_ready", r), {31'b0, rdy20}, 32'h0);
         check($sformatf("rst%0d_rdata", r), rd20, 32'h0);
         check($sformatf("rst%0d_mis", r),   {31'b0, mis20}, 32'h0);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      wait_pulse(32'h40, 32'h0, lat, pcyc);
      check("rst_release_latency", lat, L20);
      go_idle();

      for (int i = 0; i < 14; i++) begin
         txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, pcyc);
         check($sformatf("v%0d_latency", i), lat, L20);
         if (vecs[i].chk_rd) check($sformatf("v%0d_rdata", i), rd_s, vecs[i].exp_rd);
         check($sformatf("v%0d_mis", i), {31'b0, mis_s}, {31'b0, vecs[i].exp_mis});
         go_idle();
      end

      // Reset in BUSY cycle 7 of a store: no pulse, outputs cleared, array untouched.
      pulses = 0;
      @(posedge clk); #1;
      memwrite_m  = 1'b1;
      aluout_m    = 32'h80;
      writedata_m = 32'h1234_5678;
      @(negedge clk);
      if (rdy20) pulses++;
      for (int i = 1; i <= 7; i++) begin
         @(posedge clk); #1;
         if (i == 7) begin
            reset      = 1'b1;
            memwrite_m = 1'b0;
         end
         @(negedge clk);
         if (rdy20) pulses++;
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      if (rdy20) pulses++;
      check("midrst_rdata", rd20, 32'h0);
      check("midrst_mis", {31'b0, mis20}, 32'h0);
      repeat (L20 + 2) begin
         @(negedge clk);
         if (rdy20) pulses++;
      end
      check("midrst_no_pulse", pulses, 0);
      txn(1'b1, 1'b0, 32'h80, 32'h0, lat, pcyc);
      check("midrst_load_latency", lat, L20);
      check("midrst_load_rdata", rd20, 32'h0);
      check("midrst_load_mis", {31'b0, mis20}, 32'h0);
      go_idle();

      // Back-to-back loads on the LATENCY=5 instance.
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      use5  = 1'b1;
      txn(1'b0, 1'b1, 32'h0, 32'hCAFE_F00D, lat, pcyc);
      check("l5_st0_latency", lat, L5);
      go_idle();
      txn(1'b0, 1'b1, 32'h4, 32'h600D_D00D, lat, pcyc);
      check("l5_st1_latency", lat, L5);
      go_idle();
      txn(1'b1, 1'b0, 32'h0, 32'h0, lat, pcyc);
      p1 = pcyc;
      check("b2b_ld0_latency", lat, L5);
      check("b2b_ld0_rdata", rd5, 32'hCAFE_F00D);
      txn(1'b1, 1'b0, 32'h4, 32'h0, lat, pcyc);
      check("b2b_ld1_latency", lat, L5);
      check("b2b_ld1_rdata", rd5, 32'h600D_D00D);
      check("b2b_pulse_gap", pcyc - p1, L5 + 1);
      check("b2b_mis", {31'b0, mis5}, 32'h0);
      go_idle();
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
